// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
//
// Front end of the drink machine coin path. Raw chute sensor levels are
// synchronized, debounced and turned into clean single-cycle coin pulses.
// Overlapping coins and coins inserted while the machine is empty are
// refused with a coin_reject pulse. A sensor held high for too long after
// a coin decision latches a sticky jam flag that only reset clears.
//
// Handshake: there is no valid/ready pairing here. Every output pulse is a
// one-cycle strobe that the consumer must take in the cycle it is high;
// there is no backpressure. At most one of nickel_in / dime_in /
// quarter_in / coin_reject is high in any cycle.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   nickel_sense   raw nickel sensor level (asynchronous to clk)
//   dime_sense     raw dime sensor level (asynchronous to clk)
//   quarter_sense  raw quarter sensor level (asynchronous to clk)
//   empty          machine out of cans (synchronous to clk)
//   nickel_in      one-cycle accepted-nickel pulse
//   dime_in        one-cycle accepted-dime pulse
//   quarter_in     one-cycle accepted-quarter pulse
//   coin_reject    one-cycle refused-coin pulse (overlap or empty)
//   jam            sticky jam flag
//   busy           high whenever the FSM is not idle (one cycle behind state)
// ---------------------------------------------------------------------------
module coin_acceptor #(
    parameter int DEBOUNCE   = 4,   // 1..15
    parameter int GAP_CYCLES = 2,   // 0..15
    parameter int JAM_LIMIT  = 64   // 2..255
) (
    input  logic clk,
    input  logic reset,
    input  logic nickel_sense,
    input  logic dime_sense,
    input  logic quarter_sense,
    input  logic empty,
    output logic nickel_in,
    output logic dime_in,
    output logic quarter_in,
    output logic coin_reject,
    output logic jam,
    output logic busy
);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_DEBOUNCE     = 3'd1,
        ST_WAIT_RELEASE = 3'd2,
        ST_GAP          = 3'd3,
        ST_JAM          = 3'd4
    } state_t;

    localparam logic [3:0] DEB_LIM   = 4'(DEBOUNCE);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(JAM_LIMIT - 1);

    // Sensor vectors are ordered {nickel, dime, quarter}.
    logic [2:0] sync1;
    logic [2:0] s;

    state_t     state, state_nx;
    logic [2:0] coin_q, coin_nx;
    logic [3:0] deb_cnt, deb_nx;
    logic [7:0] hold_cnt, hold_nx;
    logic [3:0] gap_cnt, gap_nx;
    logic [2:0] accept_nx;
    logic       reject_nx;

    logic any_high;
    logic multi_high;

    assign any_high   = |s;
    assign multi_high = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);

    // Two-flop synchronizer per sensor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 3'b000;
            s     <= 3'b000;
        end else begin
            sync1 <= {nickel_sense, dime_sense, quarter_sense};
            s     <= sync1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            coin_q   <= 3'b000;
            deb_cnt  <= 4'd0;
            hold_cnt <= 8'd0;
            gap_cnt  <= 4'd0;
        end else begin
            state    <= state_nx;
            coin_q   <= coin_nx;
            deb_cnt  <= deb_nx;
            hold_cnt <= hold_nx;
            gap_cnt  <= gap_nx;
        end
    end

    // Next-state and pulse decode.
    always_comb begin
        state_nx  = state;
        coin_nx   = coin_q;
        deb_nx    = deb_cnt;
        hold_nx   = hold_cnt;
        gap_nx    = gap_cnt;
        accept_nx = 3'b000;
        reject_nx = 1'b0;

        case (state)
            ST_IDLE: begin
                if (multi_high) begin
                    reject_nx = 1'b1;
                    hold_nx   = 8'd0;
                    state_nx  = ST_WAIT_RELEASE;
                end else if (any_high) begin
                    if (DEBOUNCE == 1) begin
                        // A single sample is enough: decide right here.
                        if (empty) reject_nx = 1'b1;
                        else       accept_nx = s;
                        hold_nx  = 8'd0;
                        state_nx = ST_WAIT_RELEASE;
                    end else begin
                        coin_nx  = s;
                        deb_nx   = 4'd1;
                        state_nx = ST_DEBOUNCE;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if ((s & coin_q) == 3'b000) begin
                    // Captured sensor dropped before the count: a glitch.
                    deb_nx   = 4'd0;
                    state_nx = ST_IDLE;
                end else if ((s & ~coin_q) != 3'b000) begin
                    reject_nx = 1'b1;
                    deb_nx    = 4'd0;
                    hold_nx   = 8'd0;
                    state_nx  = ST_WAIT_RELEASE;
                end else if (deb_cnt == DEB_LIM) begin
                    // empty only matters on this accept edge.
                    if (empty) reject_nx = 1'b1;
                    else       accept_nx = coin_q;
                    deb_nx   = 4'd0;
                    hold_nx  = 8'd0;
                    state_nx = ST_WAIT_RELEASE;
                end else begin
                    deb_nx = deb_cnt + 4'd1;
                end
            end

            ST_WAIT_RELEASE: begin
                if (!any_high) begin
                    hold_nx = 8'd0;
                    gap_nx  = 4'd0;
                    if (GAP_CYCLES == 0) state_nx = ST_IDLE;
                    else                 state_nx = ST_GAP;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx = ST_JAM;
                end else begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end

            ST_GAP: begin
                // Sensors are ignored here; anything still high at exit
                // is seen by IDLE as a brand new coin.
                if (gap_cnt == GAP_LAST) begin
                    gap_nx   = 4'd0;
                    state_nx = ST_IDLE;
                end else begin
                    gap_nx = gap_cnt + 4'd1;
                end
            end

            ST_JAM: begin
                state_nx = ST_JAM;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nickel_in   <= 1'b0;
            dime_in     <= 1'b0;
            quarter_in  <= 1'b0;
            coin_reject <= 1'b0;
            jam         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            nickel_in   <= accept_nx[2];
            dime_in     <= accept_nx[1];
            quarter_in  <= accept_nx[0];
            coin_reject <= reject_nx;
            jam         <= (state_nx == ST_JAM);
            busy        <= (state != ST_IDLE);
        end
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage that turns raw coin-chute sensor levels into the clean single-cycle nickel_in / dime_in / quarter_in pulses consumed by the drink-machine top level. Each sensor is synchronized and debounced. Overlapping coins are rejected, and coins are refused while the machine reports empty. Sticky jam detection covers a sensor held high indefinitely. Sits directly upstream of the vending voters and takes empty back from the can counter.

Parameters:
DEBOUNCE, 4, consecutive synchronized high samples required to accept a coin (legal 1..15)
GAP_CYCLES, 2, idle cycles enforced after all sensors release before the next coin is considered (legal 0..15)
JAM_LIMIT, 64, cycles a sensor may stay high after acceptance/rejection before jam is declared (legal 2..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
nickel_sense  input  1  raw nickel sensor level, asynchronous to clk
dime_sense  input  1  raw dime sensor level, asynchronous to clk
quarter_sense  input  1  raw quarter sensor level, asynchronous to clk
empty  input  1  machine out of cans (synchronous to clk)
nickel_in  output  1  one-cycle accepted-nickel pulse
dime_in  output  1  one-cycle accepted-dime pulse
quarter_in  output  1  one-cycle accepted-quarter pulse
coin_reject  output  1  one-cycle pulse: coin refused (overlap or empty)
jam  output  1  sticky jam flag, cleared only by reset
busy  output  1  high whenever FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Reset (incl. mid-operation) forces: all outputs 0, synchronizers 0, counters 0, FSM to IDLE.
- Sync: each *_sense passes through a 2-flop synchronizer. The FSM sees only the synchronized values s_n, s_d, s_q.
- All outputs are registered. At most one of nickel_in/dime_in/quarter_in/coin_reject is high in any cycle. Each pulse is exactly 1 cycle.
- FSM states: IDLE, DEBOUNCE, WAIT_RELEASE, GAP, JAM.
- IDLE:
  - No sensor high: stay.
  - Exactly one high: capture coin type, deb_cnt=1, go to DEBOUNCE.
  - Two or more high: pulse coin_reject, go to WAIT_RELEASE.
- DEBOUNCE:
  - Captured sensor low: go to IDLE, no pulse (glitch filtered).
  - Any other sensor high: pulse coin_reject, go to WAIT_RELEASE.
  - Otherwise increment deb_cnt.
  - Edge at which deb_cnt==DEBOUNCE with sensor still high: go to WAIT_RELEASE. Pulse the captured type's *_in if empty=0; pulse coin_reject instead if empty=1. empty is sampled on that edge.
  - DEBOUNCE=1: accept on the first IDLE sample. IDLE emits the pulse directly and skips the DEBOUNCE state.
- Latency: raw sensor sampled high at edge E0 and held continuously. The pulse is high in the cycle after edge E(DEBOUNCE+2); with the default, after E6.
- WAIT_RELEASE:
  - hold_cnt increments each cycle any sensor is high.
  - All sensors low: hold_cnt=0, go to GAP (or directly to IDLE if GAP_CYCLES=0).
  - hold_cnt reaching JAM_LIMIT: go to JAM, jam=1.
- GAP: gap_cnt counts GAP_CYCLES cycles, then IDLE. Sensors are ignored during GAP. A sensor still high at exit is handled fresh in IDLE as a new coin.
- JAM: jam=1. No pulses emitted and all sensors ignored. Exit only via reset.
- Counters: deb_cnt and gap_cnt are 4 bits, hold_cnt is 8 bits. None wrap, because every limit check precedes overflow.
- empty changing mid-debounce has no effect; only its value at the accept edge matters.

Test Plan:
- Reset, then dime_sense high 10 cycles, empty=0 -> dime_in high exactly 1 cycle, after edge E6. busy high from E3 until GAP ends. No other pulses.
- nickel_sense high 3 cycles then low (DEBOUNCE=4) -> no pulse on any output. FSM back in IDLE, busy low.
- quarter_sense and nickel_sense raised on the same edge for 8 cycles -> single coin_reject pulse, no *_in pulse. Then GAP (2 cycles), then IDLE.
- empty=1, dime_sense high 10 cycles -> coin_reject pulse at the same cycle dime_in would have pulsed; dime_in stays 0.
- quarter_sense held high 80 cycles -> quarter_in pulse once, jam=1 about 64 cycles later. A subsequent nickel_sense pulse of 10 cycles gives no output. reset clears jam to 0.
- Assert reset mid-DEBOUNCE (dime_sense high 3 cycles) and keep the sensor high -> all outputs 0 immediately (asynchronous). After release, dime_in pulses DEBOUNCE+2 edges after the first post-reset sample.
